mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/mem_arb_timer.sv | 27 ++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } arb_state_e;
endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle counter; expired_o flags the TIMEOUT-th enabled cycle.
module mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                                 cnt_d = '0;
    else if (en_i && (cnt_q != CW'(TIMEOUT)))  cnt_d = cnt_q + 1'b1;
  end

  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port RAM; data side has priority.
// Optional MEM_ARB_TIMEOUT_EN aborts a stuck access after TIMEOUT busy cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ack_o,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  input  logic              ram_ready_i,
  output logic              stall_o,
  output logic              err_o
);
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be >= 1");
  end

  arb_state_e        state_q, state_d;
  logic              if_req_q, if_req_d, mem_req_q, mem_req_d;
  logic              ram_req_q, ram_req_d, ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              if_ack_q, if_ack_d, mem_ack_q, mem_ack_d;
  logic [DATA_W-1:0] if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
  logic              busy, expired, done;
  logic [DATA_W-1:0] done_data;

  assign busy      = (state_q != IDLE);
  assign done      = busy && (ram_ready_i || expired);
  // An aborted access returns zero; a real ready always wins over expiry.
  assign done_data = ram_ready_i ? ram_rdata_i : '0;

`ifdef MEM_ARB_TIMEOUT_EN
  logic err_q, err_d;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (busy),
    .clr_i    (!busy),
    .expired_o(expired)
  );

  always_comb begin
    err_d = busy && expired && !ram_ready_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign expired = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    // Requests are registered once, masked by the ack that just retired them.
    if_req_d    = if_req_i & ~if_ack_q;
    mem_req_d   = (mem_read_i | mem_write_i) & ~mem_ack_q;
    case (state_q)
      IDLE: begin
        if (mem_req_q && !mem_ack_q) begin
          state_d     = BUSY_MEM;
          ram_req_d   = 1'b1;
          ram_we_d    = mem_write_i;
          ram_addr_d  = mem_addr_i;
          ram_wdata_d = mem_wdata_i;
        end else if (if_req_q && !if_ack_q) begin
          state_d     = BUSY_IF;
          ram_req_d   = 1'b1;
          ram_we_d    = 1'b0;
          ram_addr_d  = if_addr_i;
          ram_wdata_d = '0;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        if (done) begin
          state_d   = IDLE;
          ram_req_d = 1'b0;
          if (state_q == BUSY_IF) begin
            if_ack_d  = 1'b1;
            if_data_d = done_data;
          end else begin
            mem_ack_d = 1'b1;
            if (!ram_we_q) mem_rdata_d = done_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      if_req_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      if_req_q    <= if_req_d;
      mem_req_q   <= mem_req_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_req_o   = ram_req_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign if_ack_o    = if_ack_q;
  assign mem_ack_o   = mem_ack_q;
  assign if_data_o   = if_data_q;
  assign mem_rdata_o = mem_rdata_q;
  assign stall_o     = (if_req_i & ~if_ack_q) | ((mem_read_i | mem_write_i) & ~mem_ack_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; completions are checked against a scoreboard.
module tb_mem_arbiter;
  logic        clk = 1'b0, rst_i = 1'b0;
  logic        if_req_i = 1'b0, mem_read_i = 1'b0, mem_write_i = 1'b0, ram_ready_i = 1'b0;
  logic [31:0] if_addr_i = '0, mem_addr_i = '0, mem_wdata_i = '0, ram_rdata_i = '0;
  logic [31:0] if_data_o, mem_rdata_o, ram_addr_o, ram_wdata_o;
  logic        if_ack_o, mem_ack_o, ram_req_o, ram_we_o, stall_o, err_o;

  typedef struct { bit is_mem; logic [31:0] data; } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .ram_ready_i(ram_ready_i),
    .stall_o(stall_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop(input bit is_mem, input logic [31:0] d);
    exp_t e;
    if (sb.size() == 0) begin
      chk(is_mem ? "unexpected_mem_ack" : "unexpected_if_ack", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk("sb_source", 64'(is_mem), 64'(e.is_mem));
    chk("sb_data", 64'(d), 64'(e.data));
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk); #1;
    if (if_ack_o)  pop(1'b0, if_data_o);
    if (mem_ack_o) pop(1'b1, mem_rdata_o);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!ram_req_o && n < 10) begin cyc(); n++; end
    chk(tag, 64'(ram_req_o), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_ram_req", 64'(ram_req_o), 0);
    chk("rst_ram_addr", 64'(ram_addr_o), 0);
    chk("rst_acks", 64'({if_ack_o, mem_ack_o, err_o}), 0);
    chk("rst_data", 64'({if_data_o, mem_rdata_o}), 0);
    cyc(); cyc();
    rst_i = 1'b1;
    cyc();

    // Fetch only: ack in cycle 3, stall through cycles 0-2
    if_req_i = 1'b1; if_addr_i = 32'h10;
    sb.push_back('{1'b0, 32'hDEADBEEF});
    #1 chk("f_c0_stall", 64'(stall_o), 1);
    chk("f_c0_req", 64'(ram_req_o), 0);
    cyc();
    chk("f_c1_stall", 64'(stall_o), 1);
    chk("f_c1_req", 64'(ram_req_o), 0);
    cyc();
    chk("f_c2_req", 64'(ram_req_o), 1);
    chk("f_c2_addr", 64'(ram_addr_o), 64'h10);
    chk("f_c2_we", 64'(ram_we_o), 0);
    chk("f_c2_stall", 64'(stall_o), 1);
    ram_ready_i = 1'b1; ram_rdata_i = 32'hDEADBEEF;
    cyc();
    chk("f_c3_ack", 64'(if_ack_o), 1);
    chk("f_c3_req", 64'(ram_req_o), 0);
    chk("f_c3_stall", 64'(stall_o), 0);
    if_req_i = 1'b0; ram_ready_i = 1'b0;
    cyc();
    chk("f_c4_ack", 64'(if_ack_o), 0);
    chk("f_c4_data_hold", 64'(if_data_o), 64'hDEADBEEF);
    cyc();

    // Simultaneous requests: data side first, one IDLE cycle, then fetch
    if_req_i = 1'b1; if_addr_i = 32'h20;
    mem_read_i = 1'b1; mem_addr_i = 32'h40;
    sb.push_back('{1'b1, 32'hA1A1A1A1});
    sb.push_back('{1'b0, 32'hB2B2B2B2});
    cyc(); cyc();
    chk("s_mem_addr", 64'(ram_addr_o), 64'h40);
    chk("s_mem_req", 64'(ram_req_o), 1);
    ram_ready_i = 1'b1; ram_rdata_i = 32'hA1A1A1A1;
    cyc();
    chk("s_mem_ack", 64'(mem_ack_o), 1);
    chk("s_idle_gap", 64'(ram_req_o), 0);
    chk("s_stall_if", 64'(stall_o), 1);
    mem_read_i = 1'b0; ram_ready_i = 1'b0;
    cyc();
    chk("s_if_req", 64'(ram_req_o), 1);
    chk("s_if_addr", 64'(ram_addr_o), 64'h20);
    ram_ready_i = 1'b1; ram_rdata_i = 32'hB2B2B2B2;
    cyc();
    chk("s_if_ack", 64'(if_ack_o), 1);
    chk("s_mem_hold", 64'(mem_rdata_o), 64'hA1A1A1A1);
    if_req_i = 1'b0; ram_ready_i = 1'b0;
    cyc(); cyc();

    // Write (read also high -> write), ready in the 5th busy cycle
    mem_write_i = 1'b1; mem_read_i = 1'b1; mem_addr_i = 32'h8; mem_wdata_i = 32'h12345678;
    sb.push_back('{1'b1, 32'hA1A1A1A1});
    wait_req("w_req_seen");
    for (int i = 0; i < 5; i++) begin
      chk("w_req", 64'(ram_req_o), 1);
      chk("w_we", 64'(ram_we_o), 1);
      chk("w_addr", 64'(ram_addr_o), 64'h8);
      chk("w_wdata", 64'(ram_wdata_o), 64'h12345678);
      chk("w_no_ack", 64'(mem_ack_o), 0);
      if (i == 1) begin mem_addr_i = 32'hFFFF; mem_wdata_i = 32'h0; end
      if (i == 4) begin ram_ready_i = 1'b1; ram_rdata_i = 32'hCAFEF00D; end
      cyc();
    end
    chk("w_ack", 64'(mem_ack_o), 1);
    chk("w_rdata_kept", 64'(mem_rdata_o), 64'hA1A1A1A1);
    mem_write_i = 1'b0; mem_read_i = 1'b0; ram_ready_i = 1'b0;
    cyc();
    chk("w_ack_once", 64'(mem_ack_o), 0);
    cyc();

    // Reset in the second BUSY_MEM cycle drops the access
    mem_read_i = 1'b1; mem_addr_i = 32'h40;
    wait_req("r_req_seen");
    cyc();
    rst_i = 1'b0;
    #1 chk("r_req_drop", 64'(ram_req_o), 0);
    chk("r_no_ack", 64'(mem_ack_o), 0);
    chk("r_addr_clr", 64'(ram_addr_o), 0);
    chk("r_rdata_clr", 64'(mem_rdata_o), 0);
    cyc(); cyc();
    chk("r_still_no_ack", 64'(mem_ack_o), 0);
    rst_i = 1'b1;
    sb.push_back('{1'b1, 32'hC3C3C3C3});
    cyc();
    chk("r_post_idle", 64'(ram_req_o), 0);
    wait_req("r_regrant");
    chk("r_regrant_addr", 64'(ram_addr_o), 64'h40);
    ram_ready_i = 1'b1; ram_rdata_i = 32'hC3C3C3C3;
    cyc();
    chk("r_ack", 64'(mem_ack_o), 1);
    mem_read_i = 1'b0; ram_ready_i = 1'b0;
    cyc(); cyc();

    // Stuck RAM: ready never arrives
    mem_read_i = 1'b1; mem_addr_i = 32'h4;
`ifdef MEM_ARB_TIMEOUT_EN
    sb.push_back('{1'b1, 32'h0});
    begin
      int nbusy = 0, n = 0;
      while (!mem_ack_o && n < 12) begin
        cyc();
        if (ram_req_o) nbusy++;
        if (!mem_ack_o) chk("t_err_early", 64'(err_o), 0);
        n++;
      end
      chk("t_ack", 64'(mem_ack_o), 1);
      chk("t_err", 64'(err_o), 1);
      chk("t_busy_cycles", 64'(nbusy), 4);
      chk("t_rdata_zero", 64'(mem_rdata_o), 0);
      chk("t_req_drop", 64'(ram_req_o), 0);
    end
    mem_read_i = 1'b0;
    cyc();
    chk("t_err_pulse", 64'(err_o), 0);
`else
    wait_req("t_req_seen");
    for (int i = 0; i < 20; i++) begin
      chk("t_req_held", 64'(ram_req_o), 1);
      chk("t_err_zero", 64'(err_o), 0);
      cyc();
    end
    sb.push_back('{1'b1, 32'h55});
    ram_ready_i = 1'b1; ram_rdata_i = 32'h55;
    cyc();
    chk("t_late_ack", 64'(mem_ack_o), 1);
    mem_read_i = 1'b0; ram_ready_i = 1'b0;
    cyc();
`endif
    chk("sb_empty", 64'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
